// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: once-per-frame snapshot of the hex/LED peripheral state and
// time-multiplexed drive of a 4-digit common-anode 7-segment display with
// a blanking gap at the start of each digit slot and on-time brightness.
module hex_scan_ctrl #(
   parameter int CDivLen     = 16,
   parameter int CBlankTicks = 2
) (
   input  logic               AClkH,
   input  logic               AResetH,
   input  logic               AClkHEn,
   input  logic [15:0]        ADataHex,
   input  logic [3:0]         ADotMask,
   input  logic [3:0]         ADigitEn,
   input  logic [3:0]         ABright,
   input  logic [CDivLen-1:0] ADivLoad,
   output logic [6:0]         ASegN,
   output logic               ADpN,
   output logic [3:0]         ADigitN,
   output logic               AFrameSync
);

   typedef enum logic [0:0] {
      S_LATCH = 1'b0,
      S_SCAN  = 1'b1
   } state_t;

   localparam logic [4:0] BLANK_C = 5'(CBlankTicks);

   // Hex digit to segment pattern, gfedcba, active-high.
   function automatic logic [6:0] hexseg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   state_t             state_r,  state_s;
   logic [CDivLen-1:0] div_r,    div_s;
   logic [1:0]         idx_r,    idx_s;
   logic [3:0]         ph_r,     ph_s;
   logic [15:0]        hex_r,    hex_s;
   logic [3:0]         dot_r,    dot_s;
   logic [3:0]         en_r,     en_s;
   logic [3:0]         bright_r, bright_s;
   logic [6:0]         seg_r,    seg_s;
   logic               dp_r,     dp_s;
   logic [3:0]         digit_r,  digit_s;
   logic               sync_r,   sync_s;

   logic [4:0]         limit_s;
   logic [4:0]         limit_clip_s;
   logic [3:0]         nib_s;
   logic               active_s;

   // Next-state logic: frame latch, tick prescaler, phase and digit index.
   always_comb begin
      state_s  = state_r;
      div_s    = div_r;
      idx_s    = idx_r;
      ph_s     = ph_r;
      hex_s    = hex_r;
      dot_s    = dot_r;
      en_s     = en_r;
      bright_s = bright_r;
      sync_s   = 1'b0;
      case (state_r)
         S_LATCH: begin
            hex_s    = ADataHex;
            dot_s    = ADotMask;
            en_s     = ADigitEn;
            bright_s = ABright;
            div_s    = ADivLoad;
            idx_s    = 2'd0;
            ph_s     = 4'd0;
            sync_s   = 1'b1;
            state_s  = S_SCAN;
         end
         S_SCAN: begin
            if (div_r == {CDivLen{1'b0}}) begin
               div_s = ADivLoad;
               // Phase wraps 15 -> 0 by natural 4-bit overflow.
               ph_s  = ph_r + 4'd1;
               if (ph_r == 4'd15) begin
                  if (idx_r == 2'd3) begin
                     state_s = S_LATCH;
                  end else begin
                     idx_s = idx_r + 2'd1;
                  end
               end else begin
                  idx_s = idx_r;
               end
            end else begin
               div_s = div_r - CDivLen'(1);
            end
         end
         default: begin
            state_s = S_LATCH;
         end
      endcase
   end

   // Output decode from next-state values so pins switch with the FSM.
   always_comb begin
      limit_s      = BLANK_C + {1'b0, bright_s};
      limit_clip_s = (limit_s > 5'd16) ? 5'd16 : limit_s;
      nib_s        = hex_s[{idx_s, 2'b00} +: 4];
      active_s     = (state_s == S_SCAN) && en_s[idx_s] &&
                     ({1'b0, ph_s} >= BLANK_C) && ({1'b0, ph_s} < limit_clip_s);
      digit_s      = 4'hF;
      seg_s        = 7'h7F;
      dp_s         = 1'b1;
      if (active_s) begin
         digit_s = ~(4'b0001 << idx_s);
         seg_s   = ~hexseg(nib_s);
         dp_s    = ~dot_s[idx_s];
      end else begin
         digit_s = 4'hF;
         seg_s   = 7'h7F;
         dp_s    = 1'b1;
      end
   end

   // State, shadow and output registers; synchronous reset, enable-gated update.
   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         state_r  <= S_LATCH;
         div_r    <= {CDivLen{1'b0}};
         idx_r    <= 2'd0;
         ph_r     <= 4'd0;
         hex_r    <= 16'h0000;
         dot_r    <= 4'h0;
         en_r     <= 4'h0;
         bright_r <= 4'h0;
         seg_r    <= 7'h7F;
         dp_r     <= 1'b1;
         digit_r  <= 4'hF;
         sync_r   <= 1'b0;
      end else if (AClkHEn) begin
         state_r  <= state_s;
         div_r    <= div_s;
         idx_r    <= idx_s;
         ph_r     <= ph_s;
         hex_r    <= hex_s;
         dot_r    <= dot_s;
         en_r     <= en_s;
         bright_r <= bright_s;
         seg_r    <= seg_s;
         dp_r     <= dp_s;
         digit_r  <= digit_s;
         sync_r   <= sync_s;
      end else begin
         state_r  <= state_r;
         div_r    <= div_r;
         idx_r    <= idx_r;
         ph_r     <= ph_r;
         hex_r    <= hex_r;
         dot_r    <= dot_r;
         en_r     <= en_r;
         bright_r <= bright_r;
         seg_r    <= seg_r;
         dp_r     <= dp_r;
         digit_r  <= digit_r;
         sync_r   <= sync_r;
      end
   end

   assign ASegN      = seg_r;
   assign ADpN       = dp_r;
   assign ADigitN    = digit_r;
   assign AFrameSync = sync_r;

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Scan controller for a multiplexed 4-digit common-anode 7-segment display driven from the 16-bit hex value held by the hex/LED peripheral. It snapshots the hex value, dot mask, digit-enable mask and brightness once per frame. It then time-multiplexes the four digits with an inter-digit blanking gap and per-digit on-time brightness control. It sits between the peripheral register outputs and the board pins and is clocked by the peripheral clock and clock enable.

## Interface
- CDivLen, 16: width of the tick prescaler.
- CBlankTicks, 2: ticks at the start of each digit slot with all digits off (legal 0..15).
- AClkH  in  1  peripheral clock.
- AResetH  in  1  reset, synchronous, active-high; takes effect regardless of AClkHEn.
- AClkHEn  in  1  clock enable; when 0 all state holds.
- ADataHex  in  16  hex value; digit k shows ADataHex[4k+3:4k]; digit 0 is rightmost.
- ADotMask  in  4  bit k lights the decimal point of digit k.
- ADigitEn  in  4  bit k enables digit k; a disabled digit is never driven.
- ABright  in  4  on-ticks per digit slot (0 = dark).
- ADivLoad  in  CDivLen  prescaler reload; one tick every ADivLoad+1 enabled cycles.
- ASegN  out  7  segments gfedcba, active-low.
- ADpN  out  1  decimal point, active-low.
- ADigitN  out  4  digit selects, active-low, at most one low.
- AFrameSync  out  1  one-cycle pulse marking the shadow-register load.

## Operation
- All registers update only on AClkH edges with AClkHEn=1, except reset.
- FSM states:
  - sLatch: lasts one enabled cycle.
    - Copies ADataHex, ADotMask, ADigitEn and ABright into shadow registers.
    - Sets FDiv=ADivLoad, FIdx=0, FPh=0.
    - Asserts AFrameSync for that cycle, then moves to sScan.
  - sScan: on each enabled cycle, if FDiv==0 a tick occurs and FDiv reloads from ADivLoad; otherwise FDiv decrements.
    - On each tick FPh increments.
    - When FPh==15 on a tick: FPh wraps to 0. If FIdx==3, go to sLatch; otherwise FIdx increments.
- Digit FIdx is active iff all of the following hold: the shadow enable bit for FIdx is set, FPh ≥ CBlankTicks, and FPh < min(16, CBlankTicks+shadow bright).
- Outputs are registered and computed from the next-state values, so they change on the same edge as the FSM.
  - When a digit is active: ADigitN has only bit FIdx low, ASegN = ~hexseg(shadow nibble), ADpN = ~shadow dot[FIdx].
  - When no digit is active: ADigitN=4'hF, ASegN=7'h7F, ADpN=1.
- hexseg (gfedcba, active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Input sampling:
  - ADataHex, ADotMask, ADigitEn and ABright changes mid-frame have no effect until the next sLatch (no tearing).
  - ADivLoad is sampled at each reload.

## Timing
- Reset values: state sLatch, FIdx=0, FPh=0, FDiv=0, shadows 0, ASegN=7'h7F, ADpN=1, ADigitN=4'hF, AFrameSync=0.
- The first AFrameSync occurs on the first enabled cycle after reset deasserts.
- Frame length is 1 + 64·(ADivLoad+1) enabled cycles. With ADivLoad=0 this is 65, so AFrameSync has a period of 65 cycles.
- Per slot, a digit is on for max(0, min(ABright, 16−CBlankTicks)) ticks.
- Blank gap between consecutive active digits is ≥ CBlankTicks ticks.
  - With CBlankTicks=0 and ABright=15 the gap between consecutive digits is one tick.
- When AClkHEn=0, all outputs hold, AFrameSync included: a pulse lasts exactly one enabled cycle.
- Reset asserted mid-frame forces reset values on the next AClkH edge. The frame restarts with sLatch.

## Test plan
- **Reset release:** hold AResetH 3 cycles with AClkHEn=1 -> ADigitN=F, ASegN=7F, ADpN=1, AFrameSync=0. Release -> AFrameSync=1 for exactly one cycle.
- **Full-brightness scan:** ADivLoad=0, CBlankTicks=2, ABright=15, ADigitEn=F, ADotMask=0, ADataHex=16'h12AF. Per digit, 2 cycles dark, then 14 cycles with:
  - ADigitN=E, ASegN=0E (F);
  - then ADigitN=D, ASegN=08 (A);
  - then ADigitN=B, ASegN=24 (2);
  - then ADigitN=7, ASegN=79 (1).
  - AFrameSync every 65 cycles.
- **Brightness control:**
  - ABright=4 -> each digit low for exactly 4 cycles at FPh 2..5.
  - ABright=0 -> ADigitN=F for the whole frame.
  - ABright=15 -> clipped to 14.
- **No tearing:** change ADataHex to 16'h0000 while FIdx=1 -> digits 2 and 3 still show 2 and 1. Next frame shows ASegN=40 on all digits.
- **Masks:** ADigitEn=4'b0101, ADotMask=4'b0100 -> ADigitN never equals D or 7. ADpN=0 only while ADigitN=B.
- **Clock enable and mid-frame reset:** AClkHEn high 1 cycle in 3, ADivLoad=3 -> AFrameSync period 771 AClkH cycles. Then assert AResetH for one cycle with AClkHEn=0 mid-slot -> reset values on the next edge, and a new AFrameSync on the first enabled cycle after release.
